// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory-access stage (MemCtrl sizes, load select, FSM states).
package mem_pkg;
    localparam logic [2:0] MC_B  = 3'b000;
    localparam logic [2:0] MC_H  = 3'b001;
    localparam logic [2:0] MC_W  = 3'b010;
    localparam logic [2:0] MC_BU = 3'b100;
    localparam logic [2:0] MC_HU = 3'b101;
    localparam logic [1:0] SZ_B  = 2'b00;
    localparam logic [1:0] SZ_H  = 2'b01;
    localparam logic [1:0] RS_LOAD = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Halves need an even byte offset, words need a zero offset.
    function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] off);
        return (sz == SZ_H && off[0]) || (sz != SZ_B && sz != SZ_H && off != 2'b00);
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: picks the addressed byte/half/word out of a response word and sign/zero-extends it.
module load_align
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            off,
    input  logic [2:0]            ctrl,
    output logic [DATA_WIDTH-1:0] data
);
    logic [2*DATA_WIDTH-1:0] rot;
    logic [DATA_WIDTH-1:0]   lane;
    logic                    sext;

    // Rotating right keeps lane arithmetic modulo the word for unaligned offsets.
    always_comb begin
        rot  = {rdata, rdata} >> {off, 3'b000};
        lane = rot[DATA_WIDTH-1:0];
        sext = ~ctrl[2];
        data = ctrl[1:0] == SZ_B ? {{(DATA_WIDTH-8){sext & lane[7]}}, lane[7:0]} :
               ctrl[1:0] == SZ_H ? {{(DATA_WIDTH-16){sext & lane[15]}}, lane[15:0]} : lane;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory pipeline stage driving a single-outstanding cache request and the writeback registers.
// Optional MEM_MISALIGN_CHECK_EN flags misaligned accesses instead of issuing them.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int READ_DATA_WIDTH = 5,
    parameter int SRC_WIDTH       = 2,
    parameter int MEM_CTRL_WIDTH  = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       valid_m,
    input  logic [DATA_WIDTH-1:0]      PCPlus4_m,
    input  logic [DATA_WIDTH-1:0]      ALUResult_m,
    input  logic [DATA_WIDTH-1:0]      WriteData_m,
    input  logic [READ_DATA_WIDTH-1:0] Rd_m,
    input  logic                       RegWrite_m,
    input  logic [SRC_WIDTH-1:0]       ResultSrc_m,
    input  logic                       MemWrite_m,
    input  logic [MEM_CTRL_WIDTH-1:0]  MemCtrl_m,
    output logic                       stall_m,
    output logic                       req_valid,
    input  logic                       req_ready,
    output logic                       req_we,
    output logic [DATA_WIDTH-1:0]      req_addr,
    output logic [DATA_WIDTH-1:0]      req_wdata,
    output logic [DATA_WIDTH/8-1:0]    req_wstrb,
    input  logic                       resp_valid,
    input  logic [DATA_WIDTH-1:0]      resp_rdata,
    output logic                       valid_w,
    output logic [DATA_WIDTH-1:0]      ReadData_w,
    output logic [DATA_WIDTH-1:0]      ALUResult_w,
    output logic [DATA_WIDTH-1:0]      PCPlus4_w,
    output logic [READ_DATA_WIDTH-1:0] Rd_w,
    output logic                       RegWrite_w,
    output logic [SRC_WIDTH-1:0]       ResultSrc_w,
    output logic                       misalign_w
);
    localparam int STRB_W = DATA_WIDTH / 8;

    state_e                     state_q, state_d;
    logic                       valid_w_q, valid_w_d;
    logic [DATA_WIDTH-1:0]      read_data_w_q, read_data_w_d;
    logic [DATA_WIDTH-1:0]      alu_result_w_q, alu_result_w_d;
    logic [DATA_WIDTH-1:0]      pc_plus4_w_q, pc_plus4_w_d;
    logic [READ_DATA_WIDTH-1:0] rd_w_q, rd_w_d;
    logic                       reg_write_w_q, reg_write_w_d;
    logic [SRC_WIDTH-1:0]       result_src_w_q, result_src_w_d;
    logic                       misalign_w_q, misalign_w_d;

    logic                       is_store, is_load, mem_op, mis, issue, done;
    logic [1:0]                 sz, off;
    logic [STRB_W-1:0]          strb_base;
    logic [2*STRB_W-1:0]        strb_rot;
    logic [DATA_WIDTH-1:0]      wdata_rep, load_data;
    logic [2*DATA_WIDTH-1:0]    wdata_rot;

    load_align #(.DATA_WIDTH(DATA_WIDTH)) u_load_align (
        .rdata (resp_rdata),
        .off   (off),
        .ctrl  (MemCtrl_m[2:0]),
        .data  (load_data)
    );

    always_comb begin
        sz       = MemCtrl_m[1:0];
        off      = ALUResult_m[1:0];
        is_store = valid_m && MemWrite_m;
        is_load  = valid_m && !MemWrite_m && ResultSrc_m == SRC_WIDTH'(RS_LOAD);
        mem_op   = is_store || is_load;
`ifdef MEM_MISALIGN_CHECK_EN
        mis      = mem_op && misaligned(sz, off);
`else
        mis      = 1'b0;
`endif
        issue    = state_q == ST_IDLE && mem_op && !mis;
        req_valid = rst_n && (issue || state_q == ST_REQ);
        // Upstream is held while stalled, so the m-stage operands still describe the op in REQ/WAIT.
        done     = state_q == ST_IDLE ? valid_m && (!mem_op || mis || (req_ready && is_store)) :
                   state_q == ST_REQ  ? req_ready && is_store : resp_valid;
        stall_m  = rst_n && (state_q != ST_IDLE || issue) && !done;
        state_d  = state_q == ST_WAIT ? (resp_valid ? ST_IDLE : ST_WAIT) :
                   req_valid ? (req_ready ? (is_store ? ST_IDLE : ST_WAIT) : ST_REQ) : state_q;
        req_we    = MemWrite_m;
        req_addr  = {ALUResult_m[DATA_WIDTH-1:2], 2'b00};
        strb_base = sz == SZ_B ? STRB_W'(1) : sz == SZ_H ? STRB_W'(3) : {STRB_W{1'b1}};
        strb_rot  = {strb_base, strb_base} << off;
        req_wstrb = strb_rot[2*STRB_W-1:STRB_W];
        wdata_rep = sz == SZ_B ? {STRB_W{WriteData_m[7:0]}} :
                    sz == SZ_H ? {(DATA_WIDTH/16){WriteData_m[15:0]}} : WriteData_m;
        wdata_rot = {wdata_rep, wdata_rep} << {off, 3'b000};
        req_wdata = wdata_rot[2*DATA_WIDTH-1:DATA_WIDTH];
        valid_w_d      = done;
        read_data_w_d  = done ? (is_load && !mis ? load_data : '0) : read_data_w_q;
        alu_result_w_d = done ? ALUResult_m : alu_result_w_q;
        pc_plus4_w_d   = done ? PCPlus4_m : pc_plus4_w_q;
        rd_w_d         = done ? Rd_m : rd_w_q;
        reg_write_w_d  = done ? RegWrite_m && !mis : reg_write_w_q;
        result_src_w_d = done ? ResultSrc_m : result_src_w_q;
        misalign_w_d   = done ? mis : misalign_w_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            valid_w_q      <= 1'b0;
            read_data_w_q  <= '0;
            alu_result_w_q <= '0;
            pc_plus4_w_q   <= '0;
            rd_w_q         <= '0;
            reg_write_w_q  <= 1'b0;
            result_src_w_q <= '0;
            misalign_w_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            valid_w_q      <= valid_w_d;
            read_data_w_q  <= read_data_w_d;
            alu_result_w_q <= alu_result_w_d;
            pc_plus4_w_q   <= pc_plus4_w_d;
            rd_w_q         <= rd_w_d;
            reg_write_w_q  <= reg_write_w_d;
            result_src_w_q <= result_src_w_d;
            misalign_w_q   <= misalign_w_d;
        end
    end

    assign valid_w     = valid_w_q;
    assign ReadData_w  = read_data_w_q;
    assign ALUResult_w = alu_result_w_q;
    assign PCPlus4_w   = pc_plus4_w_q;
    assign Rd_w        = rd_w_q;
    assign RegWrite_w  = reg_write_w_q;
    assign ResultSrc_w = result_src_w_q;
    assign misalign_w  = misalign_w_q;
endmodule
